p_autoreset_stage: RTL and testbench

- Output P-register stage of the DSP slice, sitting directly downstream of the pattern detector. It closes the feedback loop.
- Registers the 48-bit ALU result into P.
- Applies the auto-reset policy, driven by the detector's pd/pbd flags.
- Keeps sticky overflow/underflow status and a saturating count of auto-reset events, for accumulator/counter use cases such as terminal-count reset.

---
 rtl/p_autoreset_stage.sv | 107 ++++++++++
 tb/tb_p_autoreset_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_autoreset_stage.sv
`default_nettype none
// ============================================================================
// p_autoreset_stage : DSP P-register with pattern-driven auto-reset, sticky
// overflow/underflow status and a saturating auto-reset event counter.
// Rev 1.0
// ============================================================================
module p_autoreset_stage #(
  parameter int    WIDTH            = 48,
  parameter string AUTORESET_PATDET = "NO_RESET",
  parameter int    CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cep,
  input  logic                 rstp,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 pd,
  input  logic                 pbd,
  input  logic                 ov_f,
  input  logic                 un_f,
  input  logic                 clr_status,
  output logic [WIDTH-1:0]     p_out,
  output logic                 autoreset_evt,
  output logic                 ovf_sticky,
  output logic                 unf_sticky,
  output logic [CNT_WIDTH-1:0] evt_cnt
);

  localparam logic [1:0] c_MODE_NONE      = 2'd0;
  localparam logic [1:0] c_MODE_MATCH     = 2'd1;
  localparam logic [1:0] c_MODE_NOT_MATCH = 2'd2;

  // Unrecognised mode strings fall back to no auto-reset.
  localparam logic [1:0] c_MODE =
      (AUTORESET_PATDET == "RESET_MATCH")     ? c_MODE_MATCH     :
      (AUTORESET_PATDET == "RESET_NOT_MATCH") ? c_MODE_NOT_MATCH :
                                                c_MODE_NONE;

  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  logic [WIDTH-1:0]     p_q,       p_d;
  logic                 pd_hist_q, pd_hist_d;
  logic                 evt_q,     evt_d;
  logic                 ovf_q,     ovf_d;
  logic                 unf_q,     unf_d;
  logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 w_ar;
  logic                 w_fire;

  always_comb begin
    case (c_MODE)
      c_MODE_MATCH:     w_ar = pd;
      c_MODE_NOT_MATCH: w_ar = pd_hist_q & ~pd & ~pbd;
      default:          w_ar = 1'b0;
    endcase
  end

  // An auto-reset that coincides with rstp is swallowed: no pulse, no count.
  assign w_fire = w_ar & ~rstp;

  always_comb begin
    p_d = p_q;
    if (rstp || w_ar) begin
      p_d = '0;
    end else if (cep) begin
      p_d = alu_out;
    end

    pd_hist_d = rstp ? 1'b0 : pd;
    evt_d     = w_fire;
    ovf_d     = ov_f | (ovf_q & ~clr_status);
    unf_d     = un_f | (unf_q & ~clr_status);

    cnt_d = cnt_q;
    if (clr_status) begin
      cnt_d = CNT_WIDTH'(w_fire);
    end else if (w_fire && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      pd_hist_q <= 1'b0;
      evt_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      p_q       <= p_d;
      pd_hist_q <= pd_hist_d;
      evt_q     <= evt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign p_out         = p_q;
  assign autoreset_evt = evt_q;
  assign ovf_sticky    = ovf_q;
  assign unf_sticky    = unf_q;
  assign evt_cnt       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_p_autoreset_stage.sv
`default_nettype none
// Bench for p_autoreset_stage: four instances (NO_RESET, RESET_MATCH,
// RESET_NOT_MATCH, RESET_MATCH with a 2-bit counter) share one stimulus.
module tb_p_autoreset_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cep, rstp, pd, pbd, ov_f, un_f, clr;
  logic [47:0] alu;

  logic [3:0][47:0] d_p;
  logic [3:0]       d_evt, d_ovf, d_unf;
  logic [15:0]      cnt_nr, cnt_rm, cnt_rnm;
  logic [1:0]       cnt_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one entry per instance (0=NR,1=RM,2=RNM,3=SAT).
  logic [47:0] m_p   [4];
  bit          m_evt [4];
  int          m_cnt [4];
  bit          m_ovf, m_unf, m_prev_pd;
  int          mode  [4] = '{0, 1, 2, 1};
  int          cmax  [4] = '{65535, 65535, 65535, 3};

  always #5 clk = ~clk;

  p_autoreset_stage #(.WIDTH(48), .AUTORESET_PATDET("NO_RESET"), .CNT_WIDTH(16)) u_nr (
    .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_out(alu), .pd(pd), .pbd(pbd),
    .ov_f(ov_f), .un_f(un_f), .clr_status(clr), .p_out(d_p[0]), .autoreset_evt(d_evt[0]),
    .ovf_sticky(d_ovf[0]), .unf_sticky(d_unf[0]), .evt_cnt(cnt_nr));

  p_autoreset_stage #(.WIDTH(48), .AUTORESET_PATDET("RESET_MATCH"), .CNT_WIDTH(16)) u_rm (
    .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_out(alu), .pd(pd), .pbd(pbd),
    .ov_f(ov_f), .un_f(un_f), .clr_status(clr), .p_out(d_p[1]), .autoreset_evt(d_evt[1]),
    .ovf_sticky(d_ovf[1]), .unf_sticky(d_unf[1]), .evt_cnt(cnt_rm));

  p_autoreset_stage #(.WIDTH(48), .AUTORESET_PATDET("RESET_NOT_MATCH"), .CNT_WIDTH(16)) u_rnm (
    .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_out(alu), .pd(pd), .pbd(pbd),
    .ov_f(ov_f), .un_f(un_f), .clr_status(clr), .p_out(d_p[2]), .autoreset_evt(d_evt[2]),
    .ovf_sticky(d_ovf[2]), .unf_sticky(d_unf[2]), .evt_cnt(cnt_rnm));

  p_autoreset_stage #(.WIDTH(48), .AUTORESET_PATDET("RESET_MATCH"), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp), .alu_out(alu), .pd(pd), .pbd(pbd),
    .ov_f(ov_f), .un_f(un_f), .clr_status(clr), .p_out(d_p[3]), .autoreset_evt(d_evt[3]),
    .ovf_sticky(d_ovf[3]), .unf_sticky(d_unf[3]), .evt_cnt(cnt_sat));

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt_nr);
      1:       return int'(cnt_rm);
      2:       return int'(cnt_rnm);
      default: return int'(cnt_sat);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_p[i] = '0; m_evt[i] = 0; m_cnt[i] = 0;
    end
    m_ovf = 0; m_unf = 0; m_prev_pd = 0;
  endtask

  // Applies the behavioural rules for one clock edge given the sampled inputs.
  task automatic model_step(input bit c_cep, input bit c_rstp, input bit c_pd, input bit c_pbd,
                            input bit c_ov, input bit c_un, input bit c_clr, input logic [47:0] c_alu);
    bit ar;
    bit fire;
    for (int i = 0; i < 4; i++) begin
      case (mode[i])
        1:       ar = c_pd;
        2:       ar = m_prev_pd && !c_pd && !c_pbd;
        default: ar = 0;
      endcase
      fire = ar && !c_rstp;
      if (c_rstp || ar) m_p[i] = '0;
      else if (c_cep)   m_p[i] = c_alu;
      m_evt[i] = fire;
      if (c_clr)                          m_cnt[i] = fire ? 1 : 0;
      else if (fire && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
    end
    m_ovf     = c_ov || (m_ovf && !c_clr);
    m_unf     = c_un || (m_unf && !c_clr);
    m_prev_pd = c_rstp ? 0 : c_pd;
  endtask

  task automatic cycle();
    bit          s_cep, s_rstp, s_pd, s_pbd, s_ov, s_un, s_clr;
    logic [47:0] s_alu;
    s_cep = cep; s_rstp = rstp; s_pd = pd; s_pbd = pbd;
    s_ov = ov_f; s_un = un_f; s_clr = clr; s_alu = alu;
    @(posedge clk);
    #1;
    model_step(s_cep, s_rstp, s_pd, s_pbd, s_ov, s_un, s_clr, s_alu);
  endtask

  task automatic quiesce();
    rstp = 1; clr = 1; pd = 0; pbd = 0; ov_f = 0; un_f = 0; cep = 0;
    cycle();
    rstp = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; cep = 0; rstp = 0; pd = 0; pbd = 0; ov_f = 0; un_f = 0; clr = 0; alu = '0;
    model_reset();
    #3;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (d_p[i] !== 48'h0 || d_evt[i] !== 1'b0 || d_ovf[i] !== 1'b0 || d_unf[i] !== 1'b0 ||
          get_cnt(i) !== 0) begin
        n_fail++;
        $display("FAIL reset inst%0d: p=%h evt=%b ovf=%b unf=%b cnt=%0d, required all zero",
                 i, d_p[i], d_evt[i], d_ovf[i], d_unf[i], get_cnt(i));
      end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    logic [47:0] vals [3];
    vals = '{48'd5, 48'd6, 48'd7};
    cep = 1;
    for (int k = 0; k < 3; k++) begin
      alu = vals[k];
      cycle();
      n_tests++;
      if (d_p[0] !== vals[k]) begin
        n_fail++;
        $display("FAIL basic_load%0d: p=%h required %h", k, d_p[0], vals[k]);
      end
    end
    cep = 0; alu = 48'd99;
    cycle();
    n_tests++;
    if (d_p[0] !== 48'd7) begin
      n_fail++;
      $display("FAIL basic_hold: p=%h required 7", d_p[0]);
    end
    pd = 1;
    cycle();
    n_tests++;
    if (d_p[0] !== 48'd7 || d_evt[0] !== 1'b0 || cnt_nr !== 16'd0) begin
      n_fail++;
      $display("FAIL basic_no_reset_pd: p=%h evt=%b cnt=%0d required p=7 evt=0 cnt=0",
               d_p[0], d_evt[0], cnt_nr);
    end
    pd = 0;
  endtask

  task automatic test_match();
    quiesce();
    cep = 1; alu = 48'h0A; pd = 0;
    cycle();
    n_tests++;
    if (d_p[1] !== 48'h0A) begin
      n_fail++;
      $display("FAIL match_load: p=%h required 0a", d_p[1]);
    end
    pd = 1; alu = 48'h0B;
    cycle();
    n_tests++;
    if (d_p[1] !== 48'h0 || d_evt[1] !== 1'b1 || cnt_rm !== 16'd1) begin
      n_fail++;
      $display("FAIL match_clear: p=%h evt=%b cnt=%0d required p=0 evt=1 cnt=1",
               d_p[1], d_evt[1], cnt_rm);
    end
    pd = 0; cep = 0;
    cycle();
    n_tests++;
    if (d_p[1] !== 48'h0 || d_evt[1] !== 1'b0 || cnt_rm !== 16'd1) begin
      n_fail++;
      $display("FAIL match_pulse_end: p=%h evt=%b cnt=%0d required p=0 evt=0 cnt=1",
               d_p[1], d_evt[1], cnt_rm);
    end
  endtask

  task automatic test_not_match();
    quiesce();
    cep = 1; alu = 48'h55; pd = 1; pbd = 0;
    cycle();
    cycle();
    n_tests++;
    if (d_p[2] !== 48'h55 || d_evt[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL nm_while_match: p=%h evt=%b required p=55 evt=0", d_p[2], d_evt[2]);
    end
    pd = 0;
    cycle();
    n_tests++;
    if (d_p[2] !== 48'h0 || d_evt[2] !== 1'b1 || cnt_rnm !== 16'd1) begin
      n_fail++;
      $display("FAIL nm_clear: p=%h evt=%b cnt=%0d required p=0 evt=1 cnt=1",
               d_p[2], d_evt[2], cnt_rnm);
    end
    cycle();
    n_tests++;
    if (d_p[2] !== 48'h55 || d_evt[2] !== 1'b0 || cnt_rnm !== 16'd1) begin
      n_fail++;
      $display("FAIL nm_once: p=%h evt=%b cnt=%0d required p=55 evt=0 cnt=1",
               d_p[2], d_evt[2], cnt_rnm);
    end
    pd = 1;
    cycle();
    pd = 0; pbd = 1;
    cycle();
    n_tests++;
    if (d_p[2] !== 48'h55 || d_evt[2] !== 1'b0 || cnt_rnm !== 16'd1) begin
      n_fail++;
      $display("FAIL nm_to_bar: p=%h evt=%b cnt=%0d required p=55 evt=0 cnt=1",
               d_p[2], d_evt[2], cnt_rnm);
    end
    pbd = 0;
  endtask

  task automatic test_priority();
    quiesce();
    cep = 1; alu = 48'h77; pd = 0;
    cycle();
    rstp = 1; pd = 1;
    cycle();
    n_tests++;
    if (d_p[1] !== 48'h0 || d_evt[1] !== 1'b0 || cnt_rm !== 16'd0) begin
      n_fail++;
      $display("FAIL prio_rstp_ar: p=%h evt=%b cnt=%0d required p=0 evt=0 cnt=0",
               d_p[1], d_evt[1], cnt_rm);
    end
    rstp = 0; pd = 0; alu = 48'h88;
    cycle();
    n_tests++;
    if (d_p[0] !== 48'h88) begin
      n_fail++;
      $display("FAIL prio_reload: p=%h required 88", d_p[0]);
    end
    rstp = 1; cep = 0;
    cycle();
    n_tests++;
    if (d_p[0] !== 48'h0) begin
      n_fail++;
      $display("FAIL prio_rstp_no_cep: p=%h required 0", d_p[0]);
    end
    rstp = 0;
  endtask

  task automatic test_sticky();
    quiesce();
    ov_f = 1;
    cycle();
    ov_f = 0;
    cycle();
    rstp = 1;
    cycle();
    rstp = 0;
    n_tests++;
    if (d_ovf[0] !== 1'b1 || d_unf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_hold: ovf=%b unf=%b required ovf=1 unf=0", d_ovf[0], d_unf[0]);
    end
    clr = 1; un_f = 1;
    cycle();
    n_tests++;
    if (d_ovf[0] !== 1'b0 || d_unf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_clr_set: ovf=%b unf=%b required ovf=0 unf=1", d_ovf[0], d_unf[0]);
    end
    clr = 0; un_f = 0;
  endtask

  task automatic test_saturate();
    quiesce();
    pd = 1;
    repeat (5) cycle();
    n_tests++;
    if (cnt_sat !== 2'd3 || cnt_rm !== 16'd5) begin
      n_fail++;
      $display("FAIL sat_count: sat=%0d rm=%0d required sat=3 rm=5", cnt_sat, cnt_rm);
    end
    clr = 1;
    cycle();
    n_tests++;
    if (cnt_sat !== 2'd1 || cnt_rm !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_with_event: sat=%0d rm=%0d required 1 and 1", cnt_sat, cnt_rm);
    end
    clr = 0; pd = 0;
    cycle();
  endtask

  task automatic test_async_reset();
    quiesce();
    cep = 1; alu = 48'h1234; pd = 1; ov_f = 1; un_f = 1;
    cycle();
    n_tests++;
    if (d_p[2] !== 48'h1234 || d_ovf[2] !== 1'b1 || d_unf[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: p=%h ovf=%b unf=%b required 1234 1 1", d_p[2], d_ovf[2], d_unf[2]);
    end
    ov_f = 0; un_f = 0;
    #2;
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (d_p[i] !== 48'h0 || d_evt[i] !== 1'b0 || d_ovf[i] !== 1'b0 || d_unf[i] !== 1'b0 ||
          get_cnt(i) !== 0) begin
        n_fail++;
        $display("FAIL async_clear inst%0d: p=%h evt=%b ovf=%b unf=%b cnt=%0d required all zero",
                 i, d_p[i], d_evt[i], d_ovf[i], d_unf[i], get_cnt(i));
      end
    end
    model_reset();
    pd = 0; pbd = 0; cep = 0;
    @(negedge clk);
    rst_n = 1;
    cycle();
    n_tests++;
    if (d_evt[2] !== 1'b0 || cnt_rnm !== 16'd0 || d_p[2] !== 48'h0) begin
      n_fail++;
      $display("FAIL async_first_edge: evt=%b cnt=%0d p=%h required 0 0 0", d_evt[2], cnt_rnm, d_p[2]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cep  = ($urandom_range(0, 3) != 0);
      rstp = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      pd   = ($urandom_range(0, 2) == 0);
      pbd  = ($urandom_range(0, 3) == 0);
      ov_f = ($urandom_range(0, 19) == 0);
      un_f = ($urandom_range(0, 19) == 0);
      alu  = {$urandom(), $urandom()};
      cycle();
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (d_p[i] !== m_p[i] || d_evt[i] !== m_evt[i] || get_cnt(i) !== m_cnt[i] ||
            d_ovf[i] !== m_ovf || d_unf[i] !== m_unf) begin
          n_fail++;
          $display("FAIL random k=%0d inst%0d: p=%h evt=%b cnt=%0d ovf=%b unf=%b required p=%h evt=%b cnt=%0d ovf=%b unf=%b",
                   k, i, d_p[i], d_evt[i], get_cnt(i), d_ovf[i], d_unf[i],
                   m_p[i], m_evt[i], m_cnt[i], m_ovf, m_unf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_match();
    test_not_match();
    test_priority();
    test_sticky();
    test_saturate();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
